// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider.
// master: the datapath that issues divides; slave: the divider itself.
interface seq_divider_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             start;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             overflow;

   modport master (
      output dividend, divisor, start,
      input  busy, done, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  dividend, divisor, start,
      output busy, done, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock,
// followed by a one-cycle sign fix-up. Fixed latency of WIDTH+1 cycles.
// Build option: define DIV_SIGNED_EN for two's-complement operands/results;
// otherwise operands are unsigned and overflow is tied to 0.
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FIXUP} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_rem;        // partial remainder (magnitude)
   logic [WIDTH-1:0] r_quo;        // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] r_dvs_mag;
   logic [WIDTH-1:0] r_dividend;   // raw dividend, returned as remainder on /0
   logic [CW-1:0]    r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_zero;
   logic             r_ovf;

   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;
   logic             r_dz_out;
   logic             r_ov_out;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_ovf_case;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;

`ifdef DIV_SIGNED_EN
   // Magnitude of the most-negative value is simply its unsigned bit pattern.
   assign w_a_neg    = bus.dividend[WIDTH-1];
   assign w_b_neg    = bus.divisor[WIDTH-1];
   assign w_a_mag    = w_a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
   assign w_b_mag    = w_b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
   assign w_ovf_case = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (bus.divisor == {WIDTH{1'b1}});
`else
   assign w_a_neg    = 1'b0;
   assign w_b_neg    = 1'b0;
   assign w_a_mag    = bus.dividend;
   assign w_b_mag    = bus.divisor;
   assign w_ovf_case = 1'b0;
`endif

   // One restoring step: shift in next dividend bit, trial-subtract divisor.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_dvs_mag};

   // Control FSM, datapath and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvs_mag  <= '0;
         r_dividend <= '0;
         r_cnt      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_zero     <= 1'b0;
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_q_out    <= '0;
         r_r_out    <= '0;
         r_dz_out   <= 1'b0;
         r_ov_out   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_rem      <= '0;
                  r_quo      <= w_a_mag;
                  r_dvs_mag  <= w_b_mag;
                  r_dividend <= bus.dividend;
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  r_zero     <= (bus.divisor == '0);
                  r_ovf      <= w_ovf_case;
                  r_cnt      <= CW'(WIDTH);
                  r_busy     <= 1'b1;
                  r_state    <= S_DIVIDE;
               end
            end
            S_DIVIDE: begin
               if (!w_trial[WIDTH]) begin
                  r_rem <= w_trial[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) r_state <= S_FIXUP;
            end
            S_FIXUP: begin
               // Divide-by-zero bypasses the sign fix so remainder is the raw dividend.
               if (r_zero) begin
                  r_q_out <= {WIDTH{1'b1}};
                  r_r_out <= r_dividend;
               end else begin
                  r_q_out <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
                  r_r_out <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
               end
               r_dz_out <= r_zero;
               r_ov_out <= r_ovf;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_q_out;
   assign bus.remainder   = r_r_out;
   assign bus.div_by_zero = r_dz_out;
   assign bus.overflow    = r_ov_out;
endmodule
